spi_rdid_responder: RTL and testbench

SPI slave that answers the flash "Read Identification" (RDID) command.
- Receives an 8-bit opcode on SPIMOSI. When the opcode matches, returns a 24-bit device ID on SPIMISO.
- Serves as the bench/target-side partner of the team's SPI master.
- Also stands in for a flash device in FPGA loopback builds.
- Oversamples the SPI pins on the system clock.
- SPI mode 0, MSB first, chip select active-high (matches the master's chip_select).

---
 rtl/spi_rdid_responder.sv | 165 ++++++++++++++++
 tb/tb_spi_rdid_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_rdid_responder.sv
// SPI slave that answers the flash Read Identification (RDID) command.
// SPI pins are oversampled on clk: mode 0, MSB first, chip select active-high.
// After a matching opcode byte, the 24-bit device ID is shifted out on SPIMISO.
`timescale 1ns/1ps
module spi_rdid_responder #(
  parameter logic [23:0] DEVICE_ID   = 24'hEF4018,
  parameter logic [7:0]  RDID_OPCODE = 8'h9F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPICS,
  input  logic       SPIMOSI,
  output logic       SPIMISO,
  output logic       miso_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       rdid_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_RESPOND = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_last_r;
  logic                   cs_last_r;
  logic [6:0]             cmd_sr_r;    // first seven opcode bits; the eighth comes straight from the pin
  logic [22:0]            id_sr_r;     // remaining ID bits; bit 23 is presented directly on load
  logic [2:0]             bit_cnt_r;
  logic [4:0]             data_cnt_r;
  logic                   skip_fall_r; // first falling edge after the opcode keeps bit 23 on the line

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic cs_rise_s;
  logic cs_fall_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_last_r;
  assign sclk_fall_s = ~sclk_s & sclk_last_r;
  assign cs_rise_s   = cs_s & ~cs_last_r;
  assign cs_fall_s   = ~cs_s & cs_last_r;

  // Synchronize the asynchronous SPI pins and keep one extra flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
      sclk_last_r <= 1'b0;
      cs_last_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPICLK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPICS};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPIMOSI};
      sclk_last_r <= sclk_s;
      cs_last_r   <= cs_s;
    end
  end

  // Transaction FSM: opcode capture, ID shift-out and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_sr_r    <= 7'd0;
      id_sr_r     <= 23'd0;
      bit_cnt_r   <= 3'd0;
      data_cnt_r  <= 5'd0;
      skip_fall_r <= 1'b0;
      SPIMISO     <= 1'b0;
      miso_oe     <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_valid   <= 1'b0;
      rdid_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rdid_done <= 1'b0;
      if (cs_fall_s) begin
        // Chip select release aborts everything; a coincident SCLK edge is dropped.
        state_r     <= ST_IDLE;
        bit_cnt_r   <= 3'd0;
        data_cnt_r  <= 5'd0;
        skip_fall_r <= 1'b0;
        SPIMISO     <= 1'b0;
        miso_oe     <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cs_rise_s) begin
              state_r    <= ST_CMD;
              bit_cnt_r  <= 3'd0;
              data_cnt_r <= 5'd0;
              busy       <= 1'b1;
            end
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              cmd_sr_r  <= {cmd_sr_r[5:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                cmd_byte  <= {cmd_sr_r, mosi_s};
                cmd_valid <= 1'b1;
                if ({cmd_sr_r, mosi_s} == RDID_OPCODE) begin
                  id_sr_r     <= DEVICE_ID[22:0];
                  SPIMISO     <= DEVICE_ID[23];
                  miso_oe     <= 1'b1;
                  data_cnt_r  <= 5'd0;
                  skip_fall_r <= 1'b1;
                  state_r     <= ST_RESPOND;
                end else begin
                  state_r <= ST_DONE;
                end
              end
            end
          end
          ST_RESPOND: begin
            if (sclk_fall_s) begin
              if (skip_fall_r) begin
                skip_fall_r <= 1'b0;
              end else begin
                SPIMISO <= id_sr_r[22];
                id_sr_r <= {id_sr_r[21:0], 1'b0};
              end
            end else if (sclk_rise_s) begin
              data_cnt_r <= data_cnt_r + 5'd1;
              if (data_cnt_r == 5'd23) begin
                rdid_done <= 1'b1;
                SPIMISO   <= 1'b0;
                miso_oe   <= 1'b0;
                state_r   <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            SPIMISO <= 1'b0;
            miso_oe <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            SPIMISO <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Scoreboard bench for spi_rdid_responder: a bus-level SPI master drives
// directed and random transactions, pushes expected cmd_valid/rdid_done events
// into a scoreboard, and a monitor pops them whenever the DUT pulses an output.
`timescale 1ns/1ps
module tb_spi_rdid_responder;

  localparam logic [23:0] ID = 24'hEF4018;
  localparam logic [7:0]  OP = 8'h9F;
  localparam int          SS = 2;
  localparam int          H  = 8;   // SCLK half period in clk cycles (SCLK = clk/16)

  logic       clk = 1'b0;
  logic       reset;
  logic       SPICLK;
  logic       SPICS;
  logic       SPIMOSI;
  logic       SPIMISO;
  logic       miso_oe;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       rdid_done;
  logic       busy;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_cmd_q[$];
  int         exp_done = 0;

  spi_rdid_responder #(.DEVICE_ID(ID), .RDID_OPCODE(OP), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPICS(SPICS), .SPIMOSI(SPIMOSI),
    .SPIMISO(SPIMISO), .miso_oe(miso_oe), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .rdid_done(rdid_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference: the master sees ID bits MSB first on rising edges 9..32 of an RDID.
  function automatic logic ref_miso(input logic [7:0] op, input int r);
    logic [23:0] id_v;
    id_v = ID;
    if (op == OP && r >= 9 && r <= 32) return id_v[32 - r];
    return 1'b0;
  endfunction

  function automatic logic ref_oe(input logic [7:0] op, input int r);
    return (op == OP && r >= 9 && r <= 32);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},      32'(SPIMISO),   32'd0);
    chk({tag, "_oe"},        32'(miso_oe),   32'd0);
    chk({tag, "_cmd_byte"},  32'(cmd_byte),  32'd0);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_rdid_done"}, 32'(rdid_done), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One SPI transaction of nrise SCLK periods; rst_after>0 asserts reset after that period.
  task automatic xfer(input logic [7:0] op, input int nrise, input int rst_after);
    if (nrise >= 8 && (rst_after == 0 || rst_after >= 8)) exp_cmd_q.push_back(op);
    if (op == OP && nrise >= 32 && rst_after == 0) exp_done++;
    SPICS = 1'b1;
    wait_clks(H);
    chk("busy_after_cs_rise", 32'(busy), 32'd1);
    for (int r = 1; r <= nrise; r++) begin
      SPIMOSI = (r <= 8) ? op[8 - r] : 1'($urandom_range(0, 1));
      wait_clks(H);
      SPICLK = 1'b1;
      chk("miso_at_rise", 32'(SPIMISO), 32'(ref_miso(op, r)));
      chk("oe_at_rise",   32'(miso_oe), 32'(ref_oe(op, r)));
      chk("busy_at_rise", 32'(busy),    32'd1);
      wait_clks(H);
      SPICLK = 1'b0;
      if (r == rst_after) begin
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async_reset");
        SPICS = 1'b0;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(4);
        return;
      end
    end
    wait_clks(H);
    SPICS = 1'b0;
    wait_clks(SS + 1);
    chk("busy_after_cs_fall", 32'(busy),    32'd0);
    chk("miso_after_cs_fall", 32'(SPIMISO), 32'd0);
    chk("oe_after_cs_fall",   32'(miso_oe), 32'd0);
    wait_clks(H);
  endtask

  // Monitor: every DUT pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (cmd_valid === 1'b1) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_cmd_valid: got pulse with cmd_byte=%0h, required no pulse (t=%0t)", cmd_byte, $time);
        end else begin
          chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_q.pop_front()));
        end
      end
      if (rdid_done === 1'b1) begin
        if (exp_done == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rdid_done: got pulse, required no pulse (t=%0t)", $time);
        end else begin
          exp_done--;
          chk("rdid_done_oe_low", 32'(miso_oe), 32'd0);
        end
      end
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rop;
    int         rn;
    reset = 1'b0; SPICLK = 1'b0; SPICS = 1'b0; SPIMOSI = 1'b0;
    wait_clks(4);
    chk_reset_outputs("reset_state");
    reset = 1'b1;
    wait_clks(4);

    xfer(OP, 32, 0);                   // full RDID
    xfer(8'h03, 32, 0);                // non-matching opcode
    xfer(OP, 20, 0);                   // abort after 12 ID bits
    xfer(OP, 32, 0);                   // immediate second RDID
    xfer(OP, 40, 0);                   // extra SCLK periods after the ID
    xfer(OP, 18, 18);                  // async reset at ID bit 10
    chk("cmd_byte_after_reset", 32'(cmd_byte), 32'd0);
    xfer(OP, 32, 0);                   // RDID after reset

    // Chip select with idle clock: busy follows CS with synchronizer latency.
    SPICS = 1'b1;
    wait_clks(SS);
    chk("busy_before_cs_sync", 32'(busy), 32'd0);
    wait_clks(1);
    chk("busy_cs_rise_latency", 32'(busy), 32'd1);
    wait_clks(100 - SS - 1);
    SPICS = 1'b0;
    wait_clks(SS);
    chk("busy_before_cs_fall_sync", 32'(busy), 32'd1);
    wait_clks(1);
    chk("busy_cs_fall_latency", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      SPIMOSI = 1'($urandom_range(0, 1));
      wait_clks(H); SPICLK = 1'b1;
      wait_clks(H); SPICLK = 1'b0;
      chk("idle_sclk_busy", 32'(busy), 32'd0);
      chk("idle_sclk_oe",   32'(miso_oe), 32'd0);
    end

    // Random opcodes and lengths against the reference.
    for (int i = 0; i < 12; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? OP : 8'($urandom_range(0, 255));
      rn  = $urandom_range(4, 40);
      xfer(rop, rn, 0);
    end

    wait_clks(10);
    chk("scoreboard_cmd_empty", 32'(exp_cmd_q.size()), 32'd0);
    chk("scoreboard_done_empty", 32'(exp_done), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
